// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction fetch handshake between sequencer and program memory path
// The sequencer is the master: it requests and addresses, memory answers with the byte.
interface cpu_sequencer_if #(
   parameter int PC_WIDTH = 8
);
   logic                fetch_req;
   logic [PC_WIDTH-1:0] pc;
   logic                instr_valid;
   logic [7:0]          instruction;

   modport master (
      output fetch_req,
      output pc,
      input  instr_valid,
      input  instruction
   );

   modport slave (
      input  fetch_req,
      input  pc,
      output instr_valid,
      output instruction
   );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction-cycle FSM with program counter, run/step, halt and retire count
// Phase outputs decode from the state register only; instr_done is the lone ena-dependent output.
module cpu_sequencer #(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 run,
   input  logic                 step,
   cpu_sequencer_if.master      fetch,
   output logic [2:0]           state,
   output logic                 ctrl_en,
   output logic                 instr_done,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_HALT = 8'hFF;

   localparam logic [2:0] CODE_FETCH     = 3'b000;
   localparam logic [2:0] CODE_DECODE    = 3'b001;
   localparam logic [2:0] CODE_EXECUTE   = 3'b010;
   localparam logic [2:0] CODE_WRITEBACK = 3'b011;
   localparam logic [2:0] CODE_OUTPUT    = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_OUTPUT,
      ST_HALT
   } seq_state_t;

   seq_state_t           state_q;
   seq_state_t           state_d;
   logic [PC_WIDTH-1:0]  pc_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 fetch_accept;
   logic                 retire;

   assign fetch_accept = ena && (state_q == ST_FETCH) && fetch.instr_valid;
   assign retire       = ena && (state_q == ST_OUTPUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else if (ena) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (run || step) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (fetch.instr_valid) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = (fetch.instruction == OP_HALT) ? ST_HALT : ST_EXECUTE;
         end
         // NOP has nothing to write back, so it goes straight to OUTPUT
         ST_EXECUTE: begin
            state_d = (fetch.instruction == OP_NOP) ? ST_OUTPUT : ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            state_d = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else if (fetch_accept) begin
         pc_q <= pc_q + 1'b1;
      end
   end

   // Saturate rather than wrap so a long run never reports a small count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (retire && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   always_comb begin
      state           = CODE_FETCH;
      ctrl_en         = 1'b0;
      fetch.fetch_req = 1'b0;
      case (state_q)
         ST_FETCH: begin
            state           = CODE_FETCH;
            ctrl_en         = 1'b1;
            fetch.fetch_req = 1'b1;
         end
         ST_DECODE: begin
            state   = CODE_DECODE;
            ctrl_en = 1'b1;
         end
         ST_EXECUTE: begin
            state   = CODE_EXECUTE;
            ctrl_en = 1'b1;
         end
         ST_WRITEBACK: begin
            state   = CODE_WRITEBACK;
            ctrl_en = 1'b1;
         end
         ST_OUTPUT: begin
            state   = CODE_OUTPUT;
            ctrl_en = 1'b1;
         end
         default: begin
            state   = CODE_FETCH;
            ctrl_en = 1'b0;
         end
      endcase
   end

   assign fetch.pc    = pc_q;
   assign instr_count = count_q;
   assign halted      = (state_q == ST_HALT);
   assign instr_done  = retire;

endmodule
